// File: rtl/rssi_agc_pkg.sv
// rtl/rssi_agc_pkg.sv - shared types and defaults for the rssi AGC sequencer
//   Holds the FSM state encoding (enum for readable debug, plain 3-bit
//   constants for the legacy-compatible state register) and default widths.
package rssi_agc_pkg;

    localparam int DEFAULT_GAIN_W = 6;
    localparam int DEFAULT_CNT_W  = 16;

    typedef enum logic [2:0] {
        AGC_IDLE   = 3'd0,
        AGC_CLEAR  = 3'd1,
        AGC_SETTLE = 3'd2,
        AGC_DECIDE = 3'd3,
        AGC_HOLD   = 3'd4
    } agc_state_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

endpackage

// File: rtl/rssi_agc_ctrl_gain_step.sv
// rtl/rssi_agc_ctrl_gain_step.sv - combinational signed gain step with clamp
//   Ports: gain (current code), delta (signed step), gain_min/gain_max
//   (clamp window), next_gain (stepped and clamped code).
//   Clamp order makes gain_min win when gain_min > gain_max.
module agc_gain_step
    import rssi_agc_pkg::*;
#(
    parameter int GAIN_W = DEFAULT_GAIN_W
) (
    input  logic [GAIN_W-1:0]        gain,
    input  logic signed [GAIN_W+1:0] delta,
    input  logic [GAIN_W-1:0]        gain_min,
    input  logic [GAIN_W-1:0]        gain_max,
    output logic [GAIN_W-1:0]        next_gain
);

    // Two extra bits: one for carry past the top code, one for sign, so
    // neither 63+1 nor 0-4 can wrap before the clamp sees it.
    logic signed [GAIN_W+1:0] sum;
    logic signed [GAIN_W+1:0] lo;
    logic signed [GAIN_W+1:0] hi;
    logic signed [GAIN_W+1:0] capped;

    always_comb begin
        lo     = $signed({2'b00, gain_min});
        hi     = $signed({2'b00, gain_max});
        sum    = $signed({2'b00, gain}) + delta;
        capped = (sum > hi) ? hi : sum;
        if (capped < lo) begin
            capped = lo;
        end
        next_gain = capped[GAIN_W-1:0];
    end

endmodule

// File: rtl/rssi_agc_ctrl.sv
// rtl/rssi_agc_ctrl.sv - closed-loop AGC sequencer around one rssi averager
//   Inputs : clock, reset (sync, active-high), enable, freeze, rssi,
//            over_count, target_hi, target_lo, over_thresh, settle_cyc,
//            dwell_cyc, gain_min, gain_max.
//   Outputs: rssi_en (averager enable, 0 clears it), gain, gain_strobe,
//            locked, state (debug).
//   Build option AGC_FAST_ATTACK_EN: overload seen during SETTLE or HOLD
//   cuts the wait short and goes straight to DECIDE.
module rssi_agc_ctrl
    import rssi_agc_pkg::*;
#(
    parameter int               GAIN_W    = DEFAULT_GAIN_W,
    parameter logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(20),
    parameter int               STEP      = 1,
    parameter int               STEP_BIG  = 4,
    parameter int               CNT_W     = DEFAULT_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              freeze,
    input  logic [15:0]       rssi,
    input  logic [15:0]       over_count,
    input  logic [15:0]       target_hi,
    input  logic [15:0]       target_lo,
    input  logic [15:0]       over_thresh,
    input  logic [CNT_W-1:0]  settle_cyc,
    input  logic [CNT_W-1:0]  dwell_cyc,
    input  logic [GAIN_W-1:0] gain_min,
    input  logic [GAIN_W-1:0] gain_max,
    output logic              rssi_en,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_strobe,
    output logic              locked,
    output logic [2:0]        state
);

    localparam logic signed [GAIN_W+1:0] D_UP   = (GAIN_W+2)'(STEP);
    localparam logic signed [GAIN_W+1:0] D_DOWN = -(GAIN_W+2)'(STEP);
    localparam logic signed [GAIN_W+1:0] D_BIG  = -(GAIN_W+2)'(STEP_BIG);

    logic [CNT_W-1:0]         cnt;
    logic                     overload;
    logic                     too_hot;
    logic                     too_cold;
    logic                     in_window;
    logic                     fast_abort;
    logic                     gain_change;
    logic signed [GAIN_W+1:0] delta;
    logic [GAIN_W-1:0]        next_gain;

    assign overload  = over_count > over_thresh;
    assign too_hot   = rssi > target_hi;
    assign too_cold  = rssi < target_lo;
    assign in_window = !overload && !too_hot && !too_cold;

`ifdef AGC_FAST_ATTACK_EN
    assign fast_abort = overload;
`else
    assign fast_abort = 1'b0;
`endif

    // Overload outranks the rssi window; hot outranks cold.
    always_comb begin
        delta = '0;
        if (overload) begin
            delta = D_BIG;
        end else if (too_hot) begin
            delta = D_DOWN;
        end else if (too_cold) begin
            delta = D_UP;
        end
    end

    agc_gain_step #(
        .GAIN_W (GAIN_W)
    ) u_gain_step (
        .gain      (gain),
        .delta     (delta),
        .gain_min  (gain_min),
        .gain_max  (gain_max),
        .next_gain (next_gain)
    );

    // A locked decision never touches gain, even if the current code sits
    // outside a freshly reprogrammed clamp window.
    assign gain_change = !in_window && !freeze && (next_gain != gain);

    // The averager runs everywhere except IDLE and the one-cycle CLEAR.
    assign rssi_en = (state == ST_SETTLE) || (state == ST_DECIDE) ||
                     (state == ST_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            gain        <= GAIN_INIT;
            gain_strobe <= 1'b0;
            locked      <= 1'b0;
            cnt         <= '0;
        end else begin
            gain_strobe <= 1'b0;
            if (!enable) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_CLEAR;
                    end
                    ST_CLEAR: begin
                        cnt   <= settle_cyc;
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE, ST_HOLD: begin
                        if (cnt == '0 || fast_abort) begin
                            state <= ST_DECIDE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        locked <= in_window;
                        if (gain_change) begin
                            gain        <= next_gain;
                            gain_strobe <= 1'b1;
                            state       <= ST_CLEAR;
                        end else begin
                            cnt   <= dwell_cyc;
                            state <= ST_HOLD;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
